// File: rtl/irrigation_timer_controller_if.sv
// rtl/irrigation_timer_controller_if.sv - control and display signals of the irrigation timer
interface irrigation_timer_controller_if;
  logic       tick_1hz;
  logic       start;
  logic       splinker_mode_on;
  logic       stop_button;
  logic       conflicting_values;
  logic       valve_on;
  logic       sprinkler_active;
  logic       drip_active;
  logic       done;
  logic       aborted;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic [3:0] seconds_u;

  modport master (
    output tick_1hz, start, splinker_mode_on, stop_button, conflicting_values,
    input  valve_on, sprinkler_active, drip_active, done, aborted,
    input  minutes_d, minutes_u, seconds_d, seconds_u
  );

  modport slave (
    input  tick_1hz, start, splinker_mode_on, stop_button, conflicting_values,
    output valve_on, sprinkler_active, drip_active, done, aborted,
    output minutes_d, minutes_u, seconds_d, seconds_u
  );
endinterface

// File: rtl/irrigation_timer_controller.sv
// rtl/irrigation_timer_controller.sv - irrigation run sequencer with BCD mm:ss countdown
module irrigation_timer_controller #(
  parameter int SPRINKLER_MIN = 10,
  parameter int DRIP_MIN      = 25
) (
  input logic                           clock,
  input logic                           reset,
  irrigation_timer_controller_if.slave  io
);

  // Counter is BCD with a two-bit minutes tens digit, so durations cap at 39 minutes.
  generate
    if (SPRINKLER_MIN < 1 || SPRINKLER_MIN > 39) begin : g_bad_sprinkler
      $error("SPRINKLER_MIN must be in 1..39");
    end
    if (DRIP_MIN < 1 || DRIP_MIN > 39) begin : g_bad_drip
      $error("DRIP_MIN must be in 1..39");
    end
  endgenerate

  localparam logic [1:0] SPR_TENS  = 2'(SPRINKLER_MIN / 10);
  localparam logic [3:0] SPR_UNITS = 4'(SPRINKLER_MIN % 10);
  localparam logic [1:0] DRP_TENS  = 2'(DRIP_MIN / 10);
  localparam logic [3:0] DRP_UNITS = 4'(DRIP_MIN % 10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       valve_q, valve_d;
  logic       spr_q, spr_d;
  logic       drip_q, drip_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic [1:0] md_q, md_d;
  logic [3:0] mu_q, mu_d;
  logic [2:0] sd_q, sd_d;
  logic [3:0] su_q, su_d;

  logic start_ok;
  logic abort_req;
  logic at_one;

  assign start_ok  = io.start & ~io.stop_button & ~io.conflicting_values;
  assign abort_req = io.stop_button | io.conflicting_values;
  assign at_one    = (md_q == 2'd0) && (mu_q == 4'd0) && (sd_q == 3'd0) && (su_q == 4'd1);

  // State and every output are registered together so outputs change only on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      valve_q <= 1'b0;
      spr_q   <= 1'b0;
      drip_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      md_q    <= 2'd0;
      mu_q    <= 4'd0;
      sd_q    <= 3'd0;
      su_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      valve_q <= valve_d;
      spr_q   <= spr_d;
      drip_q  <= drip_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      md_q    <= md_d;
      mu_q    <= mu_d;
      sd_q    <= sd_d;
      su_q    <= su_d;
    end
  end

  // Next state: abort outranks expiry; DONE always falls back to IDLE after one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort_req)                state_d = S_IDLE;
        else if (io.tick_1hz && at_one) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next output values: load on start, BCD count-down on tick, clear on abort/expiry.
  always_comb begin
    valve_d = valve_q;
    spr_d   = spr_q;
    drip_d  = drip_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    md_d    = md_q;
    mu_d    = mu_q;
    sd_d    = sd_q;
    su_d    = su_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          valve_d = 1'b1;
          spr_d   = io.splinker_mode_on;
          drip_d  = ~io.splinker_mode_on;
          md_d    = io.splinker_mode_on ? SPR_TENS : DRP_TENS;
          mu_d    = io.splinker_mode_on ? SPR_UNITS : DRP_UNITS;
          sd_d    = 3'd0;
          su_d    = 4'd0;
        end else begin
          valve_d = 1'b0;
          spr_d   = 1'b0;
          drip_d  = 1'b0;
          md_d    = 2'd0;
          mu_d    = 4'd0;
          sd_d    = 3'd0;
          su_d    = 4'd0;
        end
      end
      S_RUN: begin
        if (abort_req || (io.tick_1hz && at_one)) begin
          valve_d = 1'b0;
          spr_d   = 1'b0;
          drip_d  = 1'b0;
          md_d    = 2'd0;
          mu_d    = 4'd0;
          sd_d    = 3'd0;
          su_d    = 4'd0;
          abort_d = abort_req;
          done_d  = ~abort_req;
        end else if (io.tick_1hz) begin
          if (su_q != 4'd0) begin
            su_d = su_q - 4'd1;
          end else begin
            su_d = 4'd9;
            if (sd_q != 3'd0) begin
              sd_d = sd_q - 3'd1;
            end else begin
              sd_d = 3'd5;
              if (mu_q != 4'd0) begin
                mu_d = mu_q - 4'd1;
              end else begin
                mu_d = 4'd9;
                md_d = md_q - 2'd1;
              end
            end
          end
        end
      end
      default: begin
        valve_d = 1'b0;
        spr_d   = 1'b0;
        drip_d  = 1'b0;
        md_d    = 2'd0;
        mu_d    = 4'd0;
        sd_d    = 3'd0;
        su_d    = 4'd0;
      end
    endcase
  end

  assign io.valve_on         = valve_q;
  assign io.sprinkler_active = spr_q;
  assign io.drip_active      = drip_q;
  assign io.done             = done_q;
  assign io.aborted          = abort_q;
  assign io.minutes_d        = md_q;
  assign io.minutes_u        = mu_q;
  assign io.seconds_d        = sd_q;
  assign io.seconds_u        = su_q;

endmodule

// File: tb/tb_irrigation_timer_controller.sv
// tb/tb_irrigation_timer_controller.sv - self-checking bench for irrigation_timer_controller
module tb_irrigation_timer_controller;
  localparam int SPR_MIN  = 1;
  localparam int DRIP_MIN = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irrigation_timer_controller_if ifc();

  irrigation_timer_controller #(
    .SPRINKLER_MIN(SPR_MIN),
    .DRIP_MIN(DRIP_MIN)
  ) dut (
    .clock(clk),
    .reset(rst),
    .io(ifc)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: phase 0 idle / 1 run / 2 done, remaining time as plain seconds.
  int m_phase = 0;
  int m_rem   = 0;
  bit m_spr   = 1'b0;
  bit m_valve = 1'b0;
  bit m_done  = 1'b0;
  bit m_abort = 1'b0;

  typedef struct {
    bit r, t, s, md, sb, cv;
    bit valve, spr, drip, dn, ab;
    int mm, ss;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input bit r, t, s, md, sb, cv, v, sp, dr, dn, ab,
                              input int mm, input int ss);
    vec_t x;
    x.r = r; x.t = t; x.s = s; x.md = md; x.sb = sb; x.cv = cv;
    x.valve = v; x.spr = sp; x.drip = dr; x.dn = dn; x.ab = ab;
    x.mm = mm; x.ss = ss;
    return x;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int pack(input bit v, input bit sp, input bit dr, input bit dn,
                              input bit ab, input int rem);
    int mm, ss;
    logic [17:0] p;
    mm = rem / 60;
    ss = rem % 60;
    p = {v, sp, dr, dn, ab, 2'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    return int'(p);
  endfunction

  function automatic int dut_vec();
    logic [17:0] v;
    v = {ifc.valve_on, ifc.sprinkler_active, ifc.drip_active, ifc.done, ifc.aborted,
         ifc.minutes_d, ifc.minutes_u, ifc.seconds_d, ifc.seconds_u};
    return int'(v);
  endfunction

  function automatic int dut_mm();
    return int'(ifc.minutes_d) * 10 + int'(ifc.minutes_u);
  endfunction

  function automatic int dut_ss();
    return int'(ifc.seconds_d) * 10 + int'(ifc.seconds_u);
  endfunction

  function automatic int dut_secs();
    return dut_mm() * 60 + dut_ss();
  endfunction

  function automatic int model_vec();
    return pack(m_valve, (m_phase == 1) && m_spr, (m_phase == 1) && !m_spr,
                m_done, m_abort, m_rem);
  endfunction

  task automatic model_step(input bit r, t, s, md, sb, cv);
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (r) begin
      m_phase = 0; m_rem = 0; m_valve = 1'b0; m_spr = 1'b0;
    end else begin
      case (m_phase)
        0: if (s && !sb && !cv) begin
          m_phase = 1;
          m_spr   = md;
          m_rem   = (md ? SPR_MIN : DRIP_MIN) * 60;
          m_valve = 1'b1;
        end
        1: begin
          if (sb || cv) begin
            m_phase = 0; m_rem = 0; m_valve = 1'b0; m_abort = 1'b1;
          end else if (t) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
              m_phase = 2; m_valve = 1'b0; m_done = 1'b1;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic cycle(input bit r, t, s, md, sb, cv);
    rst                    = r;
    ifc.tick_1hz           = t;
    ifc.start              = s;
    ifc.splinker_mode_on   = md;
    ifc.stop_button        = sb;
    ifc.conflicting_values = cv;
    @(posedge clk);
    model_step(r, t, s, md, sb, cv);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  initial begin
    ifc.tick_1hz = 1'b0;
    ifc.start = 1'b0;
    ifc.splinker_mode_on = 1'b0;
    ifc.stop_button = 1'b0;
    ifc.conflicting_values = 1'b0;

    //               r t s m sb cv  v sp dr dn ab  mm ss
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0);
    tbl[1]  = mk(0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0,  0,  0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0,  0,  0);
    tbl[3]  = mk(0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0,  1,  0);
    tbl[4]  = mk(0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0,  0, 59);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 58);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 58);
    tbl[7]  = mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1,  0,  0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 20,  0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 19, 59);
    tbl[11] = mk(1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0);

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].md, tbl[i].sb, tbl[i].cv);
      chk($sformatf("vec%0d", i), dut_vec(),
          pack(tbl[i].valve, tbl[i].spr, tbl[i].drip, tbl[i].dn, tbl[i].ab,
               tbl[i].mm * 60 + tbl[i].ss));
    end

    // Reset held two cycles in the middle of a run.
    cycle(0, 0, 1, 1, 0, 0);
    repeat (3) cycle(0, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    chk("rst_vec", dut_vec(), 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_idle_valve", int'(ifc.valve_on), 0);

    // Full sprinkler run with idle cycles between ticks.
    cycle(0, 0, 1, 1, 0, 0);
    chk("spr_load_secs", dut_secs(), 60);
    chk("spr_load_flag", int'(ifc.sprinkler_active), 1);
    chk("spr_load_valve", int'(ifc.valve_on), 1);
    for (int i = 0; i < 59; i++) begin
      if (i % 7 == 3) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 1, 0, 1, 0, 0);
    end
    chk("spr_last_secs", dut_secs(), 1);
    chk("spr_last_done", int'(ifc.done), 0);
    cycle(0, 1, 0, 1, 0, 0);
    chk("spr_done", int'(ifc.done), 1);
    chk("spr_done_valve", int'(ifc.valve_on), 0);
    chk("spr_done_secs", dut_secs(), 0);
    chk("spr_done_flag", int'(ifc.sprinkler_active), 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("spr_done_pulse", int'(ifc.done), 0);

    // Drip run: BCD borrows, then conflict coinciding with a tick at 00:30.
    cycle(0, 0, 1, 0, 0, 0);
    chk("drip_load_mm", dut_mm(), 20);
    cycle(0, 1, 0, 0, 0, 0);
    chk("borrow1_mm", dut_mm(), 19);
    chk("borrow1_ss", dut_ss(), 59);
    repeat (600) cycle(0, 1, 0, 0, 0, 0);
    chk("borrow601_mm", dut_mm(), 9);
    chk("borrow601_ss", dut_ss(), 59);
    repeat (569) cycle(0, 1, 0, 0, 0, 0);
    chk("at_0030", dut_secs(), 30);
    cycle(0, 1, 0, 0, 0, 1);
    chk("abort_flag", int'(ifc.aborted), 1);
    chk("abort_done", int'(ifc.done), 0);
    chk("abort_valve", int'(ifc.valve_on), 0);
    chk("abort_secs", dut_secs(), 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("abort_pulse", int'(ifc.aborted), 0);

    // Mode and start toggling mid-run are ignored.
    cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, bit'(i % 2), bit'(i % 3 == 0), bit'(i % 2 == 0), 0, 0);
      chk("toggle_spr", int'(ifc.sprinkler_active), 1);
      chk("toggle_drip", int'(ifc.drip_active), 0);
    end
    chk("toggle_secs", dut_secs(), 55);
    cycle(0, 0, 0, 0, 1, 0);

    // Held start re-arms after one IDLE cycle.
    cycle(0, 0, 1, 1, 0, 0);
    repeat (59) cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    chk("held_done", int'(ifc.done), 1);
    cycle(0, 0, 1, 1, 0, 0);
    chk("held_idle_valve", int'(ifc.valve_on), 0);
    chk("held_idle_done", int'(ifc.done), 0);
    chk("held_idle_secs", dut_secs(), 0);
    cycle(0, 0, 1, 1, 0, 0);
    chk("held_rerun_valve", int'(ifc.valve_on), 1);
    chk("held_rerun_secs", dut_secs(), 60);
    cycle(0, 0, 0, 0, 1, 0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
